// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: FSM encoding and
// byte-lane selects (lane 0 is the most significant byte, written first).
package imem_loader_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_WORD = 2'd1,
    WRITE     = 2'd2,
    DONE      = 2'd3
  } state_t;

  localparam logic [1:0] LANE_B0 = 2'd0;  // in_word[31:24]
  localparam logic [1:0] LANE_B1 = 2'd1;  // in_word[23:16]
  localparam logic [1:0] LANE_B2 = 2'd2;  // in_word[15:8]
  localparam logic [1:0] LANE_B3 = 2'd3;  // in_word[7:0]

endpackage

// File: rtl/word_byte_ser.sv
// Big-endian byte select: index 0 returns the most significant byte so that
// consecutive byte writes reconstruct the word on a big-endian read.
module word_byte_ser
  import imem_loader_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  idx,
  output logic [7:0]  out_byte
);

  always_comb begin
    out_byte = word[31:24];
    case (idx)
      LANE_B0: out_byte = word[31:24];
      LANE_B1: out_byte = word[23:16];
      LANE_B2: out_byte = word[15:8];
      LANE_B3: out_byte = word[7:0];
      default: out_byte = word[31:24];
    endcase
  end

endmodule

// File: rtl/imem_loader.sv
// Streams 32-bit words from a valid/ready source into a byte-wide instruction
// memory, holding the CPU in reset for the duration of the load.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 7
) (
  input  logic              clk,
  input  logic              R,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic              in_valid,
  input  logic [31:0]       in_word,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  state_t            state;
  logic [ADDR_W-1:0] addr_ptr;
  logic [CNT_W-1:0]  remaining;
  logic [1:0]        byte_idx;
  logic [31:0]       word_q;
  logic [ADDR_W-1:0] last_addr;
  logic [7:0]        last_data;
  logic [7:0]        ser_byte;

  word_byte_ser u_ser (
    .word     (word_q),
    .idx      (byte_idx),
    .out_byte (ser_byte)
  );

  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state     <= IDLE;
      addr_ptr  <= '0;
      remaining <= '0;
      byte_idx  <= '0;
      word_q    <= '0;
      last_addr <= '0;
      last_data <= '0;
      overflow  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          addr_ptr  <= base_addr;
          remaining <= word_count;
          overflow  <= 1'b0;
          state     <= (word_count != '0) ? WAIT_WORD : DONE;
        end
        WAIT_WORD: if (in_valid) begin
          word_q   <= in_word;
          byte_idx <= LANE_B0;
          state    <= WRITE;
        end
        WRITE: begin
          // Remember what was driven so the memory port holds it once WRITE ends.
          last_addr <= addr_ptr;
          last_data <= ser_byte;
          addr_ptr  <= addr_ptr + 1'b1;
          if (addr_ptr == '1) overflow <= 1'b1;
          byte_idx  <= byte_idx + 2'd1;
          if (byte_idx == LANE_B3) begin
            remaining <= remaining - 1'b1;
            state     <= (remaining == CNT_W'(1)) ? DONE : WAIT_WORD;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Every output is a pure function of registered state.
  assign in_ready = (state == WAIT_WORD);
  assign mem_we   = (state == WRITE);
  assign mem_addr = mem_we ? addr_ptr : last_addr;
  assign mem_data = mem_we ? ser_byte : last_data;
  assign busy     = (state != IDLE);
  assign cpu_hold = busy;
  assign done     = (state == DONE);

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 Parameter ADDR_W, default 8, SHALL set the byte-address width of the instruction memory write port.
REQ-002 Parameter CNT_W, default 7, SHALL set the width of the word-count input (max 2^CNT_W-1 words).
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 R  input  1  asynchronous active-low reset.
REQ-006 start  input  1  single-cycle load request; sampled only in IDLE.
REQ-007 base_addr  input  ADDR_W  first byte address of the load; latched on accepted start.
REQ-008 word_count  input  CNT_W  number of 32-bit words to load; latched on accepted start.
REQ-009 in_valid  input  1  source presents a word on in_word.
REQ-010 in_word  input  32  instruction word to store.
REQ-011 in_ready  output  1  loader can accept a word this cycle.
REQ-012 mem_we  output  1  byte write strobe to instruction memory.
REQ-013 mem_addr  output  ADDR_W  byte address of the current write.
REQ-014 mem_data  output  8  byte being written.
REQ-015 cpu_hold  output  1  holds PC and pipeline registers in reset while a load is in progress.
REQ-016 busy  output  1  high in every state except IDLE.
REQ-017 done  output  1  one-cycle pulse when a load completes.
REQ-018 overflow  output  1  sticky flag: a write address wrapped from 2^ADDR_W-1 to 0.

Function
REQ-019 FSM states SHALL be IDLE, WAIT_WORD, WRITE, DONE.
REQ-020 IDLE: start=1 latches base_addr into addr_ptr, word_count into remaining, and clears overflow; next state WAIT_WORD if word_count!=0, else DONE.
REQ-021 WAIT_WORD: in_ready=1; in_valid&in_ready captures in_word, resets byte_idx to 0, next state WRITE; otherwise the FSM stays in WAIT_WORD indefinitely.
REQ-022 WRITE: mem_we=1 for exactly 4 consecutive cycles, emitting in big-endian order: byte_idx 0 -> in_word[31:24], 1 -> [23:16], 2 -> [15:8], 3 -> [7:0], so that a big-endian 4-byte read at the word address returns the original word.
REQ-023 Each WRITE cycle SHALL drive mem_addr=addr_ptr, then increment addr_ptr modulo 2^ADDR_W; an increment from 2^ADDR_W-1 to 0 SHALL set overflow, and the write SHALL still occur.
REQ-024 After byte_idx 3, remaining SHALL decrement; the next state is DONE if the result is 0, else WAIT_WORD.
REQ-025 DONE: done=1 for one cycle, then IDLE unconditionally.
REQ-026 start outside IDLE SHALL be ignored; in_valid outside WAIT_WORD SHALL be ignored and not consumed.
REQ-027 in_ready, mem_we, mem_addr, mem_data, busy, cpu_hold and done SHALL be decoded from registered state only, with no combinational path from any input.
REQ-028 cpu_hold SHALL equal busy.
REQ-029 Outside WRITE, mem_we=0 and mem_addr/mem_data SHALL hold their last values.
REQ-030 Throughput: with in_valid held high, N words SHALL take exactly 5N cycles from the first WAIT_WORD cycle to the done cycle (1 handshake + 4 writes per word), followed by 1 DONE cycle.

Reset
REQ-031 R=0 SHALL immediately force IDLE, with in_ready=0, mem_we=0, mem_addr=0, mem_data=0, cpu_hold=0, busy=0, done=0, overflow=0, and remaining=0, byte_idx=0, addr_ptr=0.
REQ-032 Reset asserted mid-load SHALL abort the load without completing the partial word and without a done pulse; already-written bytes remain in memory.

Structure
REQ-033 The shared package SHALL hold the FSM state encoding (IDLE, WAIT_WORD, WRITE, DONE) and the byte-lane select constants.
REQ-034 The word-to-byte big-endian selection SHALL be one sub-module, word_byte_ser (32-bit word + 2-bit index -> 8-bit byte); the rest stays in imem_loader.

Verification
REQ-035 base_addr=0x00, word_count=1, in_word=0xE0812002 valid immediately -> writes 0xE0@0x00, 0x81@0x01, 0x20@0x02, 0x02@0x03; done 5 cycles after the first WAIT_WORD cycle; overflow=0.
REQ-036 base_addr=0x10, word_count=3, in_valid held high -> 12 writes covering 0x10..0x1B; mem_we low exactly on the 3 handshake cycles; done at cycle 15; busy=cpu_hold throughout.
REQ-037 base_addr=0xFE, word_count=1 -> writes at 0xFE, 0xFF, 0x00, 0x01; overflow=1 from the third write on, held until the next accepted start.
REQ-038 word_count=0 with start -> no mem_we; done pulse in the second cycle after start; in_ready never asserted.
REQ-039 Stall and abort: in_valid low for 7 cycles in WAIT_WORD -> in_ready stays high with no writes; start during WRITE is ignored; R=0 during byte_idx 2 -> all outputs return to reset values immediately and no done pulse occurs.
